alu_pwr_seq: RTL and testbench

Power sequencer for the switchable ALU domain. It drives the `alu_pwr_en`, `iso_en`, `save` and `restore` controls of the ALU/always-on boundary in a legal order. It gates operation starts from a requester through a req/ack handshake. It wakes the domain on demand and shuts it down on software request or after an idle timeout. It sits in the always-on domain, between the requester and the ALU control inputs.

---
 rtl/alu_pwr_pkg.sv | 57 +++++
 rtl/alu_pwr_timer.sv | 34 +++
 rtl/alu_pwr_seq.sv | 150 +++++++++++++++
 tb/tb_alu_pwr_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pwr_pkg.sv
// Shared types and constants for the ALU power sequencer.
//   pwr_state_e : sequencer state encodings
//   pwr_ctl_t   : boundary control vector {pwr_en, iso_en, save, restore}
//   ctl_of()    : per-state control vector
//   cnt_width() : dwell counter width for the given cycle parameters
package alu_pwr_pkg;

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_SAVE    = 3'd1,
    ST_ISO     = 3'd2,
    ST_OFF     = 3'd3,
    ST_PWRUP   = 3'd4,
    ST_RESTORE = 3'd5
  } pwr_state_e;

  typedef struct packed {
    logic pwr_en;
    logic iso_en;
    logic save;
    logic restore;
  } pwr_ctl_t;

  localparam pwr_ctl_t CTL_ON      = pwr_ctl_t'(4'b1000);
  localparam pwr_ctl_t CTL_SAVE    = pwr_ctl_t'(4'b1010);
  localparam pwr_ctl_t CTL_ISO     = pwr_ctl_t'(4'b1100);
  localparam pwr_ctl_t CTL_OFF     = pwr_ctl_t'(4'b0100);
  localparam pwr_ctl_t CTL_PWRUP   = pwr_ctl_t'(4'b1100);
  localparam pwr_ctl_t CTL_RESTORE = pwr_ctl_t'(4'b1101);

  // Boundary controls driven while in state s; unreachable codes look like ON.
  function automatic pwr_ctl_t ctl_of(input pwr_state_e s);
    pwr_ctl_t c;
    case (s)
      ST_ON:      c = CTL_ON;
      ST_SAVE:    c = CTL_SAVE;
      ST_ISO:     c = CTL_ISO;
      ST_OFF:     c = CTL_OFF;
      ST_PWRUP:   c = CTL_PWRUP;
      ST_RESTORE: c = CTL_RESTORE;
      default:    c = CTL_ON;
    endcase
    return c;
  endfunction

  // Width holding the largest dwell value without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alu_pwr_timer.sv
// Loadable saturating down counter shared by the sequencer's dwell phases.
//   clk, rst_n : clock, async active-low reset (resets to RST_VAL)
//   load       : load load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one, holding at zero
//   done_c     : counter is zero (combinational)
module alu_pwr_timer #(
  parameter int unsigned W       = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done_c
);

  logic [W-1:0] cnt_q;

  // Count register; saturates at zero so long waits never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= W'(RST_VAL);
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// Power sequencer for the switchable ALU domain: orders save/isolation/switch
// on power-down and switch/restore/de-isolation on power-up, and gates ALU
// starts through a req/ack handshake.
//   clk, rst_n     : clock, async active-low reset
//   start_req      : requester op request (level, held until start_ack)
//   sleep_req      : software power-down request (level)
//   wake_req       : software power-up request (level)
//   auto_sleep_en  : enable idle-timeout power-down
//   busy           : ALU busy
//   start_out      : one-cycle start pulse to the ALU
//   start_ack      : same as start_out, returned to the requester
//   alu_pwr_en     : power switch enable
//   iso_en         : isolation enable
//   save, restore  : one-cycle retention pulses
//   domain_ready   : high only in ON
//   pwr_state      : current state encoding
module alu_pwr_seq
  import alu_pwr_pkg::*;
#(
  parameter int unsigned ISO_CYCLES    = 2,
  parameter int unsigned PWR_UP_CYCLES = 4,
  parameter int unsigned IDLE_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_req,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       auto_sleep_en,
  input  logic       busy,
  output logic       start_out,
  output logic       start_ack,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       domain_ready,
  output logic [2:0] pwr_state
);

  localparam int unsigned CW = cnt_width(ISO_CYCLES, PWR_UP_CYCLES, IDLE_CYCLES);

  pwr_state_e    state_q, state_d;
  logic          start_q, start_d;
  logic          wake_pend_q, wake_pend_d;
  logic          ready_q;
  pwr_ctl_t      ctl_q;
  logic          tmr_load, tmr_dec, tmr_done;
  logic [CW-1:0] tmr_val;

  // One counter serves ISO/PWRUP dwell and, in ON, idle counting (counts down
  // from IDLE_CYCLES-1, so zero means the idle timeout is reached).
  alu_pwr_timer #(
    .W       (CW),
    .RST_VAL (IDLE_CYCLES - 1)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done_c   (tmr_done)
  );

  // Next state, start pulse, timer control.
  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    wake_pend_d = wake_pend_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_val     = CW'(IDLE_CYCLES - 1);
    case (state_q)
      ST_ON: begin
        if (start_req && !busy && !start_q) begin
          start_d  = 1'b1;
          tmr_load = 1'b1;
        end else if (!busy && !start_q &&
                     (sleep_req || (auto_sleep_en && tmr_done))) begin
          state_d = ST_SAVE;
        end else if (!busy && !start_req && !start_q) begin
          tmr_dec = 1'b1;
        end else begin
          tmr_load = 1'b1;
        end
      end
      ST_SAVE: begin
        // A wake seen mid power-down is remembered and acted on from OFF.
        wake_pend_d = wake_pend_q | wake_req;
        state_d     = ST_ISO;
        tmr_load    = 1'b1;
        tmr_val     = CW'(ISO_CYCLES - 1);
      end
      ST_ISO: begin
        wake_pend_d = wake_pend_q | wake_req;
        if (tmr_done) state_d = ST_OFF;
        else          tmr_dec = 1'b1;
      end
      ST_OFF: begin
        if (wake_req || start_req || wake_pend_q) begin
          state_d     = ST_PWRUP;
          wake_pend_d = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = CW'(PWR_UP_CYCLES - 1);
        end
      end
      ST_PWRUP: begin
        if (tmr_done) state_d = ST_RESTORE;
        else          tmr_dec = 1'b1;
      end
      ST_RESTORE: begin
        state_d  = ST_ON;
        tmr_load = 1'b1;
      end
      default: begin
        state_d     = ST_ON;
        wake_pend_d = 1'b0;
        tmr_load    = 1'b1;
      end
    endcase
  end

  // State and output registers; outputs follow the next state so they change
  // on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ON;
      start_q     <= 1'b0;
      wake_pend_q <= 1'b0;
      ready_q     <= 1'b1;
      ctl_q       <= CTL_ON;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      wake_pend_q <= wake_pend_d;
      ready_q     <= (state_d == ST_ON);
      ctl_q       <= ctl_of(state_d);
    end
  end

  assign start_out    = start_q;
  assign start_ack    = start_q;
  assign alu_pwr_en   = ctl_q.pwr_en;
  assign iso_en       = ctl_q.iso_en;
  assign save         = ctl_q.save;
  assign restore      = ctl_q.restore;
  assign domain_ready = ready_q;
  assign pwr_state    = 3'(state_q);

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Directed bench for alu_pwr_seq with default parameters.
module tb_alu_pwr_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start_req, sleep_req, wake_req, auto_sleep_en, busy;
  logic start_out, start_ack, alu_pwr_en, iso_en, save, restore, domain_ready;
  logic [2:0] pwr_state;
  logic [9:0] obs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_pwr_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_req     (start_req),
    .sleep_req     (sleep_req),
    .wake_req      (wake_req),
    .auto_sleep_en (auto_sleep_en),
    .busy          (busy),
    .start_out     (start_out),
    .start_ack     (start_ack),
    .alu_pwr_en    (alu_pwr_en),
    .iso_en        (iso_en),
    .save          (save),
    .restore       (restore),
    .domain_ready  (domain_ready),
    .pwr_state     (pwr_state)
  );

  assign obs = {alu_pwr_en, iso_en, save, restore, domain_ready,
                start_out, start_ack, pwr_state};

  // Expected observation vector for a state code and start/ack level.
  function automatic logic [9:0] exp_v(input logic [2:0] st, input logic ack);
    logic [3:0] c;
    case (st)
      3'd0:    c = 4'b1000;
      3'd1:    c = 4'b1010;
      3'd2:    c = 4'b1100;
      3'd3:    c = 4'b0100;
      3'd4:    c = 4'b1100;
      3'd5:    c = 4'b1101;
      default: c = 4'bxxxx;
    endcase
    return {c, (st == 3'd0), ack, ack, st};
  endfunction

  task automatic chk(input string tag, input logic [2:0] st, input logic ack);
    logic [9:0] e;
    e = exp_v(st, ack);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start_req = 1'b0; sleep_req = 1'b0; wake_req = 1'b0;
    auto_sleep_en = 1'b0; busy = 1'b0;

    // Reset
    #12;
    chk("reset_hold", 3'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("reset_release", 3'd0, 1'b0);

    // Sleep then wake
    sleep_req = 1'b1;
    tick(); chk("sleep_save_c1", 3'd1, 1'b0);
    sleep_req = 1'b0;
    tick(); chk("sleep_iso_c2", 3'd2, 1'b0);
    tick(); chk("sleep_iso_c3", 3'd2, 1'b0);
    tick(); chk("sleep_off_c4", 3'd3, 1'b0);
    repeat (6) tick();
    chk("off_hold_c10", 3'd3, 1'b0);
    wake_req = 1'b1; sleep_req = 1'b1;
    tick(); chk("wake_beats_sleep_c11", 3'd4, 1'b0);
    wake_req = 1'b0; sleep_req = 1'b0;
    repeat (3) tick();
    chk("pwrup_c14", 3'd4, 1'b0);
    tick(); chk("restore_c15", 3'd5, 1'b0);
    tick(); chk("on_c16", 3'd0, 1'b0);

    // Start from OFF
    sleep_req = 1'b1;
    tick(); sleep_req = 1'b0;
    repeat (3) tick();
    chk("off_before_start", 3'd3, 1'b0);
    start_req = 1'b1;
    tick(); chk("start_pwrup_first", 3'd4, 1'b0);
    repeat (3) tick();
    chk("start_pwrup_last", 3'd4, 1'b0);
    tick(); chk("start_restore", 3'd5, 1'b0);
    tick(); chk("start_on_no_ack", 3'd0, 1'b0);
    tick(); chk("start_ack", 3'd0, 1'b1);
    tick(); chk("no_second_ack", 3'd0, 1'b0);
    start_req = 1'b0;
    tick(); chk("ack_after_drop", 3'd0, 1'b0);

    // Sleep blocked by busy
    busy = 1'b1; sleep_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("busy_blocks_sleep", 3'd0, 1'b0);
    end
    busy = 1'b0;
    tick(); chk("save_after_busy", 3'd1, 1'b0);
    sleep_req = 1'b0;
    repeat (3) tick();
    chk("busy_path_off", 3'd3, 1'b0);
    wake_req = 1'b1;
    tick(); wake_req = 1'b0;
    repeat (4) tick();
    chk("busy_path_restore", 3'd5, 1'b0);
    tick(); chk("busy_path_on", 3'd0, 1'b0);

    // Start has priority over sleep
    start_req = 1'b1; sleep_req = 1'b1;
    tick(); chk("start_over_sleep", 3'd0, 1'b1);
    start_req = 1'b0;
    tick(); chk("no_save_with_start", 3'd0, 1'b0);
    tick(); chk("save_after_start", 3'd1, 1'b0);
    sleep_req = 1'b0;
    repeat (3) tick();
    chk("prio_path_off", 3'd3, 1'b0);
    wake_req = 1'b1;
    tick(); wake_req = 1'b0;
    repeat (5) tick();
    chk("prio_path_on", 3'd0, 1'b0);

    // Auto-sleep after 8 idle cycles
    auto_sleep_en = 1'b1;
    repeat (7) tick();
    chk("auto_idle_7", 3'd0, 1'b0);
    tick(); chk("auto_save", 3'd1, 1'b0);
    repeat (3) tick();
    chk("auto_off", 3'd3, 1'b0);
    wake_req = 1'b1;
    tick(); wake_req = 1'b0;
    repeat (5) tick();
    chk("auto_on_again", 3'd0, 1'b0);

    // Start at idle cycle 5 restarts the idle count
    repeat (5) tick();
    start_req = 1'b1;
    tick(); chk("idle_start_ack", 3'd0, 1'b1);
    start_req = 1'b0;
    tick(); chk("idle_not_expired_early", 3'd0, 1'b0);
    repeat (7) tick();
    chk("idle_restart_hold", 3'd0, 1'b0);
    tick(); chk("idle_restart_save", 3'd1, 1'b0);
    auto_sleep_en = 1'b0;

    // Wake pulsed during ISO does not abort power-down
    tick(); chk("abort_iso_c2", 3'd2, 1'b0);
    wake_req = 1'b1;
    tick(); chk("abort_iso_c3", 3'd2, 1'b0);
    wake_req = 1'b0;
    tick(); chk("abort_off_min1", 3'd3, 1'b0);
    tick(); chk("abort_pwrup", 3'd4, 1'b0);

    // Asynchronous reset during PWRUP
    #2 rst_n = 1'b0;
    #1 chk("async_reset_pwrup", 3'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick(); chk("post_reset_on", 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
